jogador_automatico: RTL
=======================

# jogador_automatico

Autonomous player for the memory game circuit: it drives the game's `jogar` and `botoes` inputs and reads back its `ganhou`/`perdeu`/`pronto` outputs. It replays a stored button sequence in growing rounds: round r presses entries 0..r. Button hold and release times are fixed. It sits beside the game circuit in the board top-level and in system benches as a self-checking stimulus source, and it reports the game outcome.

## Interface
Parameters:
- `T_JOGAR`, default 5, cycles `jogar` is held high.
- `T_APERTO`, default 10, cycles each button stays pressed.
- `T_PAUSA`, default 10, idle cycles after the `jogar` pulse and after each release.

Ports:
- `clock` in 1: single system clock.
- `reset` in 1: synchronous, active-high.
- `iniciar` in 1: start request, level-sampled in `inicial`.
- `nivel` in 1: 0 selects 8 rounds, 1 selects 16 rounds.
- `ganhou` in 1: win flag from the game.
- `perdeu` in 1: loss flag from the game.
- `erro_rodada` in 4: round where the player injects a wrong press. Used only with `JOGADOR_ERRO_EN`.
- `erro_pos` in 4: position within that round for the wrong press. Used only with `JOGADOR_ERRO_EN`.
- `jogar` out 1: start pulse to the game.
- `botoes` out 4: one-hot button press, or 0000.
- `rodada` out 4: current round, 0-based.
- `fim` out 1: session finished.
- `venceu` out 1: game reported a win.
- `db_estado` out 4: FSM state encoding.

## Operation
- FSM states: `inicial`, `pulso_jogar`, `pausa_inicial`, `aperta`, `solta`, `proxima`, `espera_resultado`, `fim_ganhou`, `fim_perdeu`.
- `inicial`: all outputs 0. When `iniciar`=1, go to `pulso_jogar` and clear the round, position and timer.
- `pulso_jogar`: `jogar`=1 for T_JOGAR cycles, then go to `pausa_inicial`.
- `pausa_inicial`: T_PAUSA cycles with `botoes`=0000, then go to `aperta`.
- `aperta`: `botoes`=rom[pos] for T_APERTO cycles, then go to `solta`.
- `solta`: `botoes`=0000 for T_PAUSA cycles, then go to `proxima`.
- `proxima` (1 cycle), first matching rule wins:
  - pos<rodada: pos+1, go to `aperta`.
  - rodada<last round (7 or 15): rodada+1, pos=0, go to `aperta`.
  - otherwise: go to `espera_resultado`.
- `espera_resultado`: wait for `ganhou` or `perdeu`.
- Abort rule: in any state except `inicial`/`fim_*`, `perdeu`=1 goes to `fim_perdeu` and `ganhou`=1 goes to `fim_ganhou` on the next edge. `perdeu` wins if both are high.
- `fim_ganhou`: `fim`=1, `venceu`=1. `fim_perdeu`: `fim`=1, `venceu`=0.
- Both `fim_*` states hold until `iniciar`=1, which restarts at `pulso_jogar`.
- `nivel` is latched on the `iniciar` edge. Later changes are ignored until the next session.
- `botoes` is always either 0000 or exactly one-hot.

## Timing
- Reset value of every output is 0. State is `inicial`; counters are 0.
- Reset mid-operation returns to `inicial` on that edge. `botoes` and `jogar` drop the same edge.
- The `jogar` rising edge comes 1 cycle after `iniciar` is sampled.
- Round r, from its first press to the end of its last release, takes (r+1)×(T_APERTO+T_PAUSA+1) cycles. The +1 is the `proxima` cycle.
- The timer is a down-counter, width clog2(max(T_JOGAR, T_APERTO, T_PAUSA)+1). It reloads on every state entry.
- Round and position counters are 4 bits. No wrap-around is possible because the last-round check happens in `proxima`.

## Configuration
- `JOGADOR_ERRO_EN` defined:
  - At rodada==`erro_rodada` and pos==`erro_pos`, `aperta` drives rom[pos] rotated left by 1. Example: 0001 becomes 0010; 1000 becomes 0001.
  - This fires once per session.
- Undefined: the error inputs are ignored and every press is correct. The ports stay present so the interface is unchanged.

## Structure
- Shared package `jogador_pkg` holds:
  - the state encoding constants,
  - the round limits (7 and 15),
  - the button-code constants (0001, 0010, 0100, 1000).
- Sub-module `rom_jogadas`: 16×4 asynchronous-read ROM with contents 1,2,4,8,4,2,1,1,2,2,4,4,8,8,1,4 (one-hot codes). The game circuit's sequence ROM holds the same contents.

## Test plan
- Reset, then `iniciar`=1 for 1 cycle -> `jogar`=1 for exactly 5 cycles starting 1 cycle later. 10 cycles later `botoes`=0001 for 10 cycles.
- `nivel`=0 against a game model that never flags -> 36 presses in total. The final round is 1,2,4,8,4,2,1,1. The block then sits in `espera_resultado` with `rodada`=7.
- Game model asserts `ganhou` during `espera_resultado` -> `fim`=1 and `venceu`=1 next cycle. `iniciar` then restarts with `jogar`=1.
- `JOGADOR_ERRO_EN`, `erro_rodada`=2, `erro_pos`=1 -> that press is 0100 instead of 0010. The model raises `perdeu`, giving `fim`=1, `venceu`=0, `botoes`=0000.
- `reset` mid-`aperta` in round 3 -> `botoes`=0000 and `rodada`=0 on that edge, with the FSM in `inicial`.
- `ganhou` and `perdeu` high in the same cycle -> the FSM enters `fim_perdeu`.

Source files
------------

// File: rtl/jogador_pkg.sv
// Shared definitions for the autonomous memory-game player: state encoding,
// round limits, button codes and the rotate helper used for the injected error.
package jogador_pkg;

  typedef enum logic [3:0] {
    StInicial       = 4'd0,
    StPulsoJogar    = 4'd1,
    StPausaInicial  = 4'd2,
    StAperta        = 4'd3,
    StSolta         = 4'd4,
    StProxima       = 4'd5,
    StEspera        = 4'd6,
    StFimGanhou     = 4'd7,
    StFimPerdeu     = 4'd8
  } estado_e;

  localparam logic [3:0] UltimaRodadaN0 = 4'd7;
  localparam logic [3:0] UltimaRodadaN1 = 4'd15;

  localparam logic [3:0] Botao0 = 4'b0001;
  localparam logic [3:0] Botao1 = 4'b0010;
  localparam logic [3:0] Botao2 = 4'b0100;
  localparam logic [3:0] Botao3 = 4'b1000;

  function automatic logic [3:0] rot_esq(input logic [3:0] b);
    return {b[2:0], b[3]};
  endfunction

endpackage

// File: rtl/jogador_automatico_if.sv
// Player <-> game bus: start pulse and button presses out, win/loss flags back.
interface jogador_automatico_if;
  logic       jogar;
  logic [3:0] botoes;
  logic       ganhou;
  logic       perdeu;

  modport master (output jogar, output botoes, input ganhou, input perdeu);
  modport slave  (input jogar, input botoes, output ganhou, output perdeu);
endinterface

// File: rtl/rom_jogadas.sv
// 16x4 asynchronous-read ROM holding the one-hot button sequence shared with the game.
module rom_jogadas
  import jogador_pkg::*;
(
  input  logic [3:0] endereco_i,
  output logic [3:0] dado_o
);

  always_comb begin
    dado_o = Botao0;
    case (endereco_i)
      4'd0:  dado_o = Botao0;
      4'd1:  dado_o = Botao1;
      4'd2:  dado_o = Botao2;
      4'd3:  dado_o = Botao3;
      4'd4:  dado_o = Botao2;
      4'd5:  dado_o = Botao1;
      4'd6:  dado_o = Botao0;
      4'd7:  dado_o = Botao0;
      4'd8:  dado_o = Botao1;
      4'd9:  dado_o = Botao1;
      4'd10: dado_o = Botao2;
      4'd11: dado_o = Botao2;
      4'd12: dado_o = Botao3;
      4'd13: dado_o = Botao3;
      4'd14: dado_o = Botao0;
      4'd15: dado_o = Botao2;
      default: dado_o = Botao0;
    endcase
  end

endmodule

// File: rtl/jogador_automatico.sv
// Autonomous memory-game player replaying the stored sequence in growing rounds.
// Optional wrong-press injection is enabled with the JOGADOR_ERRO_EN macro.
module jogador_automatico
  import jogador_pkg::*;
#(
  parameter int unsigned T_JOGAR  = 5,
  parameter int unsigned T_APERTO = 10,
  parameter int unsigned T_PAUSA  = 10
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  iniciar,
  input  logic                  nivel,
  input  logic [3:0]            erro_rodada,
  input  logic [3:0]            erro_pos,
  jogador_automatico_if.master  jogo,
  output logic [3:0]            rodada,
  output logic                  fim,
  output logic                  venceu,
  output logic [3:0]            db_estado
);

  localparam int unsigned TMaxJa = (T_JOGAR > T_APERTO) ? T_JOGAR : T_APERTO;
  localparam int unsigned TMax   = (TMaxJa > T_PAUSA) ? TMaxJa : T_PAUSA;
  localparam int unsigned TW     = $clog2(TMax + 1);

  localparam logic [TW-1:0] CargaJogar  = TW'(T_JOGAR - 1);
  localparam logic [TW-1:0] CargaAperto = TW'(T_APERTO - 1);
  localparam logic [TW-1:0] CargaPausa  = TW'(T_PAUSA - 1);

  estado_e       estado_q, estado_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [3:0]    rodada_q, rodada_d;
  logic [3:0]    pos_q, pos_d;
  logic          nivel_q, nivel_d;
  logic          erro_feito_q, erro_feito_d;

  logic [3:0]    botao_rom;
  logic [3:0]    ultima;
  logic          timer_fim;
  logic          em_jogo;
  logic          erro_ativo;

  rom_jogadas u_rom (
    .endereco_i (pos_q),
    .dado_o     (botao_rom)
  );

`ifdef JOGADOR_ERRO_EN
  assign erro_ativo = !erro_feito_q && (rodada_q == erro_rodada) && (pos_q == erro_pos);
`else
  assign erro_ativo = 1'b0;
  logic unused_erro;
  assign unused_erro = ^{erro_rodada, erro_pos, erro_feito_q};
`endif

  assign ultima    = nivel_q ? UltimaRodadaN1 : UltimaRodadaN0;
  assign timer_fim = (timer_q == '0);
  assign em_jogo   = !(estado_q inside {StInicial, StFimGanhou, StFimPerdeu});

  always_comb begin
    estado_d     = estado_q;
    timer_d      = timer_q;
    rodada_d     = rodada_q;
    pos_d        = pos_q;
    nivel_d      = nivel_q;
    erro_feito_d = erro_feito_q;

    case (estado_q)
      StInicial, StFimGanhou, StFimPerdeu: begin
        if (iniciar) begin
          estado_d     = StPulsoJogar;
          timer_d      = CargaJogar;
          rodada_d     = '0;
          pos_d        = '0;
          nivel_d      = nivel;
          erro_feito_d = 1'b0;
        end
      end
      StPulsoJogar: begin
        if (timer_fim) begin
          estado_d = StPausaInicial;
          timer_d  = CargaPausa;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      StPausaInicial: begin
        if (timer_fim) begin
          estado_d = StAperta;
          timer_d  = CargaAperto;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      StAperta: begin
        if (timer_fim) begin
          estado_d = StSolta;
          timer_d  = CargaPausa;
          if (erro_ativo) erro_feito_d = 1'b1;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      StSolta: begin
        if (timer_fim) begin
          estado_d = StProxima;
          timer_d  = '0;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      StProxima: begin
        estado_d = StAperta;
        timer_d  = CargaAperto;
        if (pos_q < rodada_q) begin
          pos_d = pos_q + 4'd1;
        end else if (rodada_q < ultima) begin
          rodada_d = rodada_q + 4'd1;
          pos_d    = '0;
        end else begin
          estado_d = StEspera;
          timer_d  = '0;
        end
      end
      StEspera: ;
      default: estado_d = StInicial;
    endcase

    // Game outcome overrides any sequencing; loss has priority.
    if (em_jogo) begin
      if (jogo.perdeu) begin
        estado_d = StFimPerdeu;
      end else if (jogo.ganhou) begin
        estado_d = StFimGanhou;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q     <= StInicial;
      timer_q      <= '0;
      rodada_q     <= '0;
      pos_q        <= '0;
      nivel_q      <= 1'b0;
      erro_feito_q <= 1'b0;
    end else begin
      estado_q     <= estado_d;
      timer_q      <= timer_d;
      rodada_q     <= rodada_d;
      pos_q        <= pos_d;
      nivel_q      <= nivel_d;
      erro_feito_q <= erro_feito_d;
    end
  end

  always_comb begin
    jogo.jogar  = (estado_q == StPulsoJogar);
    jogo.botoes = 4'b0000;
    if (estado_q == StAperta) begin
      jogo.botoes = erro_ativo ? rot_esq(botao_rom) : botao_rom;
    end
    fim       = (estado_q == StFimGanhou) || (estado_q == StFimPerdeu);
    venceu    = (estado_q == StFimGanhou);
    rodada    = rodada_q;
    db_estado = estado_q;
  end

endmodule
